// File: rtl/conv_interleaver.sv
// Forney convolutional interleaver (DVB-C outer, I=12, M=17).
// Branch 0 is a plain two-register path. Branches 1..I-1 are delay lines
// that share one single-port read-first RAM. Each branch owns a fixed address
// window and a cyclic pointer into that window. Every byte has a latency of
// two registers, whichever branch it takes.
module conv_interleaver #(
  parameter int I         = 12,
  parameter int M         = 17,
  parameter int DWIDTH    = 8,
  parameter int ADDRWIDTH = 11
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic [DWIDTH-1:0] iData,
  input  logic              iValid,
  input  logic              iSync,
  output logic [DWIDTH-1:0] oData,
  output logic              oValid,
  output logic              oSync
);

  localparam int BW = $clog2(I);

  // Window base and last pointer value for each branch.
  // These are elaboration-time constants, so the RAM address needs no multiplier.
  logic [ADDRWIDTH-1:0] base_tbl [I];
  logic [ADDRWIDTH-1:0] last_tbl [I];

  for (genvar j = 0; j < I; j++) begin : g_tbl
    assign base_tbl[j] = ADDRWIDTH'(M * j * (j - 1) / 2);
    assign last_tbl[j] = ADDRWIDTH'((j == 0) ? 0 : j * M - 1);
  end

  logic [DWIDTH-1:0]    mem [2**ADDRWIDTH];
  logic [DWIDTH-1:0]    ram_rd_q;

  logic [BW-1:0]        br_q, br_d, eb;
  logic [ADDRWIDTH-1:0] ptr_q [I];
  logic [ADDRWIDTH-1:0] ptr_d [I];
  logic [I-1:0]         primed_q, primed_d;
  logic [ADDRWIDTH-1:0] ram_addr;
  logic                 ram_we;

  // Stage 1 holds the branch-0 byte and the flags that travel beside the RAM read.
  logic                 v1_q, v1_d;
  logic                 b0_q, b0_d;
  logic                 s1_q, s1_d;
  logic                 pr1_q, pr1_d;
  logic [DWIDTH-1:0]    d1_q, d1_d;

  // Stage 2 is the output register.
  logic                 o_valid_q, o_valid_d;
  logic                 o_sync_q, o_sync_d;
  logic [DWIDTH-1:0]    o_data_q, o_data_d;

  // Choose the branch, access the RAM, and advance the branch state.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    br_d     = br_q;
    ptr_d    = ptr_q;
    primed_d = primed_q;
    eb       = (iValid && iSync) ? '0 : br_q;
    ram_addr = base_tbl[eb] + ptr_q[eb];
    ram_we   = iValid && (eb != '0);

    if (iValid) begin
      br_d = (eb == BW'(I - 1)) ? '0 : eb + 1'b1;
    end
    if (ram_we) begin
      if (ptr_q[eb] == last_tbl[eb]) begin
        ptr_d[eb]    = '0;
        primed_d[eb] = 1'b1;
      end else begin
        ptr_d[eb] = ptr_q[eb] + 1'b1;
      end
    end

    v1_d  = iValid;
    b0_d  = (eb == '0);
    s1_d  = iValid && iSync;
    pr1_d = primed_q[eb];
    d1_d  = iData;
  end

  // Compute the output: a branch-0 byte passes through; any other branch
  // returns its RAM read, or 0x00 until that branch's window has filled.
  always_comb begin
    o_valid_d = v1_q;
    o_sync_d  = v1_q && b0_q && s1_q;
    o_data_d  = '0;
    if (v1_q) begin
      o_data_d = b0_q ? d1_q : (pr1_q ? ram_rd_q : '0);
    end
  end

  // Register branch state and both pipeline stages; reset discards in-flight bytes.
  always_ff @(posedge iClk or posedge iRst) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
    if (iRst) begin
      br_q      <= '0;
      primed_q  <= '0;
      for (int j = 0; j < I; j++) ptr_q[j] <= '0;
      v1_q      <= 1'b0;
      b0_q      <= 1'b0;
      s1_q      <= 1'b0;
      pr1_q     <= 1'b0;
      d1_q      <= '0;
      o_valid_q <= 1'b0;
      o_sync_q  <= 1'b0;
      o_data_q  <= '0;
    end else begin
      br_q      <= br_d;
      primed_q  <= primed_d;
      ptr_q     <= ptr_d;
      v1_q      <= v1_d;
      b0_q      <= b0_d;
      s1_q      <= s1_d;
      pr1_q     <= pr1_d;
      d1_q      <= d1_d;
      o_valid_q <= o_valid_d;
      o_sync_q  <= o_sync_d;
      o_data_q  <= o_data_d;
    end
  end

  // Single-port read-first RAM: the old byte is read and the new byte is written to the same address.
  always_ff @(posedge iClk) begin
    // NOTE: the RAM has no reset. Stale contents never reach oData, because the primed flags are cleared on reset.
    if (ram_we) begin
      ram_rd_q      <= mem[ram_addr];
      mem[ram_addr] <= iData;
    end
  end

  assign oData  = o_data_q;
  assign oValid = o_valid_q;
  assign oSync  = o_sync_q;

endmodule

// File: tb/tb_conv_interleaver.sv
// Scoreboard bench for conv_interleaver.
// The reference model treats each branch j as a queue of j*M bytes.
// Until that queue is full, a branch emits 0x00; after that it emits the
// oldest byte in the queue. Expected outputs go into a scoreboard queue, and
// a monitor on the falling edge pops entries and compares them with the DUT.
module tb_conv_interleaver;

  localparam int NB  = 12;
  localparam int DM  = 17;
  localparam int PKT = 204;

  logic       iClk   = 1'b0;
  logic       iRst   = 1'b1;
  logic [7:0] iData  = '0;
  logic       iValid = 1'b0;
  logic       iSync  = 1'b0;
  logic [7:0] oData;
  logic       oValid;
  logic       oSync;

  conv_interleaver dut (
    .iClk   (iClk),
    .iRst   (iRst),
    .iData  (iData),
    .iValid (iValid),
    .iSync  (iSync),
    .oData  (oData),
    .oValid (oValid),
    .oSync  (oSync)
  );

  always #5 iClk = ~iClk;

  int cyc = 0;
  always @(posedge iClk) cyc++;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [7:0] d;
    logic       s;
    int         c;
  } exp_t;

  exp_t       sb [$];
  logic [7:0] dl [NB][$];
  int         mbr  = 0;
  int         sent = 0;
  int         pos  = 0;

  logic [7:0] out_d [$];
  logic       out_s [$];
  bit         rec_en = 1'b0;

  // Drive one cycle after the rising edge, and push the expected result when the byte is valid.
  task automatic send(input logic v, input logic [7:0] d, input logic s);
    exp_t e;
    int   eb;
    @(posedge iClk);
    #1;
    iValid = v;
    iData  = d;
    iSync  = v && s;
    if (v) begin
      eb  = s ? 0 : mbr;
      mbr = (eb == NB - 1) ? 0 : eb + 1;
      e.s = 1'b0;
      e.c = cyc + 2;
      if (eb == 0) begin
        e.d = d;
        e.s = s;
      end else begin
        e.d = (dl[eb].size() == eb * DM) ? dl[eb].pop_front() : 8'h00;
        dl[eb].push_back(d);
      end
      sb.push_back(e);
      sent++;
    end
  endtask

  // Send n random packet-aligned bytes. With gaps set, every third cycle is left idle.
  task automatic stream(input int n, input bit gaps);
    int c;
    c = 0;
    for (int i = 0; i < n; i++) begin
      if (gaps && (c % 3 == 2)) begin
        send(1'b0, 8'h00, 1'b0);
        c++;
      end
      send(1'b1, 8'($urandom), pos == 0);
      pos = (pos == PKT - 1) ? 0 : pos + 1;
      c++;
    end
  endtask

  // Monitor: compare each presented output with the oldest expectation.
  always @(negedge iClk) begin
    exp_t e;
    if (!iRst) begin
      if (oValid) begin
        if (rec_en && out_d.size() < NB * PKT) begin
          out_d.push_back(oData);
          out_s.push_back(oSync);
        end
        if (sb.size() == 0) begin
          check("spurious_ovalid", {31'd0, oValid}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("odata", {24'd0, oData}, {24'd0, e.d});
          check("osync", {31'd0, oSync}, {31'd0, e.s});
          check("latency", cyc, e.c);
        end
      end else begin
        check("osync_idle", {31'd0, oSync}, 32'd0);
      end
    end
  end

  initial begin
    int idx;
    logic [7:0] kb;

    // Reset state.
    #12;
    check("rst_ovalid", {31'd0, oValid}, 32'd0);
    check("rst_odata", {24'd0, oData}, 32'd0);
    check("rst_osync", {31'd0, oSync}, 32'd0);
    @(posedge iClk);
    #1;
    iRst = 1'b0;

    // Twelve packets of ramp data, with no gaps.
    rec_en = 1'b1;
    for (int k = 0; k < NB * PKT; k++) begin
      kb = k[7:0];
      send(1'b1, kb, (k % PKT) == 0);
    end
    pos = 0;

    // Random packets with one idle slot in every three cycles.
    stream(300, 1'b1);

    // Force a resync while the branch counter sits at 5.
    while (mbr != 5) begin
      send(1'b1, 8'($urandom), 1'b0);
      pos = (pos == PKT - 1) ? 0 : pos + 1;
    end
    send(1'b1, 8'($urandom), 1'b1);
    pos = 1;
    check("resync_next_branch", mbr, 1);
    while (sent < 3000 || pos == 0) stream(1, 1'b0);

    // Direct check of the ramp: input k appears at output k + 204*(k%12), and oSync recurs every 204 outputs.
    rec_en = 1'b0;
    check("hist_len", out_d.size(), NB * PKT);
    if (out_d.size() == NB * PKT) begin
      for (int k = 0; k < NB * PKT; k++) begin
        idx = k + PKT * (k % NB);
        if (idx < NB * PKT) begin
          kb = k[7:0];
          check("ramp_pos", {24'd0, out_d[idx]}, {24'd0, kb});
        end
        check("sync_period", {31'd0, out_s[k]}, {31'd0, (k % PKT) == 0});
      end
    end

    // Reset in the middle of a packet: the outputs must clear at once, without waiting for a clock edge.
    @(posedge iClk);
    #1;
    iRst   = 1'b1;
    iValid = 1'b0;
    iSync  = 1'b0;
    #1;
    check("midrst_ovalid", {31'd0, oValid}, 32'd0);
    check("midrst_odata", {24'd0, oData}, 32'd0);
    check("midrst_osync", {31'd0, oSync}, 32'd0);
    sb.delete();
    for (int j = 0; j < NB; j++) dl[j].delete();
    mbr = 0;
    repeat (3) @(posedge iClk);
    #1;
    iRst = 1'b0;

    // Fresh stream, with stale bytes still in the RAM. The first byte has no
    // sync but must still go to branch 0. The stream is long enough for
    // branch 11 to wrap and fill.
    send(1'b1, 8'($urandom), 1'b0);
    pos = 1;
    stream(2700, 1'b0);
    send(1'b0, 8'h00, 1'b0);

    repeat (5) @(posedge iClk);
    #1;
    check("drain_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/conv_interleaver.md
Name: conv_interleaver

Overview:
- DVB-C outer convolutional interleaver (Forney, I=12, M=17), placed after RS(204,188) encoding and before byte-to-symbol mapping.
- All branch FIFOs share one single-port, read-first RAM.
- Each branch has its own wrap-around pointer (a cyclic address counter) into a fixed address window of that RAM.
- Guarantees the sync byte of every packet exits on branch 0.

Parameters:
- I, 12, number of branches.
- M, 17, delay unit in bytes; branch j delays by j*M of its own bytes.
- DWIDTH, 8, data byte width.
- ADDRWIDTH, 11, RAM address width; must satisfy 2^ADDRWIDTH >= M*I*(I-1)/2 (1122 at defaults).

Ports:
- iClk  input  1  clock, rising edge.
- iRst  input  1  asynchronous active-high reset.
- iData  input  DWIDTH  input byte.
- iValid  input  1  iData qualifier; one byte per cycle max.
- iSync  input  1  with iValid, marks the first byte (0x47/0xB8) of a packet.
- oData  output  DWIDTH  interleaved byte.
- oValid  output  1  oData qualifier.
- oSync  output  1  oData is a sync byte that entered on branch 0 with iSync.

Behaviour:
- Reset (asynchronous, iRst=1):
  - oData=0, oValid=0, oSync=0.
  - Branch counter br=0.
  - All branch pointers ptr[j]=0.
  - All primed[j]=0.
  - Pipeline valids cleared.
  - RAM contents are not cleared.
  - Reset mid-stream discards all in-flight bytes. The first valid byte after reset deasserts is treated as branch 0.
- Branch select:
  - Effective branch eb = 0 if (iValid && iSync), else br.
  - On each iValid cycle, br <= (eb==I-1) ? 0 : eb+1.
  - iSync while br!=0 forces a resync to branch 0; pointers are untouched.
  - iValid=0: no state change.
- Branch 0: no storage; the byte passes through the pipeline only.
- Branch j>=1:
  - Window base B(j) = M*j*(j-1)/2, length L(j) = j*M. Bases at defaults: B(1)=0, B(2)=17, B(11)=935, top address 1121.
  - Access: read-first at address B(eb)+ptr[eb]; write iData to the same address in the same cycle.
  - Pointer update: ptr[eb] <= (ptr[eb]==L(eb)-1) ? 0 : ptr[eb]+1. When it wraps, primed[eb] <= 1.
  - Output byte is the read data if primed was set before this access, else 0x00. This makes output deterministic before fill.
- Bases and lengths come from a constant table computed at elaboration. There is no runtime multiply.
- Latency: fixed 2 cycles for all branches.
  - iValid at edge n gives oValid at edge n+2.
  - Branch-0 data and sync travel through 2 registers to align with the RAM read path.
- oSync = 1 only for a branch-0 byte that had iSync=1.
- Throughput: one byte per cycle sustained; no backpressure.
- End-to-end, with continuous branch cycling: a byte on branch j appears at output stream index n + j*M*I (204*j at defaults).

Test Plan:
- Reset, then 204 bytes 0..203 with iSync on byte 0 -> output byte 0 = 0 with oSync=1. Every output whose source branch j>=1 is unprimed is 0x00. oValid trails iValid by exactly 2 cycles.
- Continuous stream of 12 packets of ramp data -> input byte at index k (branch k%12) appears at output index k+204*(k%12). oSync=1 exactly every 204 output bytes.
- iValid gaps (1 of every 3 cycles idle) -> output sequence identical to the gap-free case. oValid deasserted on idle slots, 2 cycles delayed.
- iSync asserted at br=5 -> that byte is routed to branch 0 with oSync=1, and the next byte goes to branch 1. Branch 5..11 pointers are unchanged (checked by the data ordering that follows).
- iRst pulse mid-packet after 3000 bytes -> outputs 0 immediately (asynchronously). Post-reset stream behaves exactly as a fresh start, outputting 0x00 for unprimed branches despite stale RAM contents.
- Branch 11 boundary: ptr[11] wraps at 186, exercising the top address 1121 -> no address overrun; the first primed branch-11 byte equals the byte written 187 branch-11 accesses earlier.
